// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies and op width.
// MDU_ACC_EN enables the MADD/MSUB accumulate ops (6/7).
package mdu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;
    localparam logic [OP_W-1:0] OP_MADD  = 3'd6;
    localparam logic [OP_W-1:0] OP_MSUB  = 3'd7;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        logic long_op;
        long_op = (op == OP_MULT) || (op == OP_MULTU) ||
                  (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_ACC_EN
        long_op = long_op || (op == OP_MADD) || (op == OP_MSUB);
`endif
        return long_op;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit result generation for the MDU (multiply, divide, accumulate).
// MDU_ACC_EN adds MADD/MSUB; otherwise ops 6/7 return the accumulator unchanged.
module mdu_core
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic [63:0]     acc,
    output logic [63:0]     result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign div_signed = (op == OP_DIV);
    assign rs_neg     = div_signed & rs_val[31];
    assign rt_neg     = div_signed & rt_val[31];
    assign rs_mag     = rs_neg ? (32'd0 - rs_val) : rs_val;
    assign rt_mag     = rt_neg ? (32'd0 - rt_val) : rt_val;
    assign divisor    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    assign q_mag      = rs_mag / divisor;
    assign r_mag      = rs_mag % divisor;
    assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = rs_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        result = acc;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                if (rt_val != 32'd0) begin
                    result = {rem, quot};
                end
            end
`ifdef MDU_ACC_EN
            OP_MADD:  result = acc + prod_s;
            OP_MSUB:  result = acc - prod_s;
`endif
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// MIPS E-stage multiply/divide unit: FSM, latency counter, pending result and HI/LO.
// Build with MDU_ACC_EN to accept MADD/MSUB.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            busy,
    output logic            md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [63:0]     pending_reg, pending_next;
    logic [31:0]     hi_reg, hi_next;
    logic [31:0]     lo_reg, lo_next;
    logic [63:0]     core_result;
    logic            long_op;
    logic [CNT_W-1:0] latency;

    mdu_core u_core (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .acc    ({hi_reg, lo_reg}),
        .result (core_result)
    );

    assign long_op  = is_long_op(op);
    assign latency  = ((op == OP_DIV) || (op == OP_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                          : CNT_W'(MULT_CYCLES);
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign busy     = (state_reg == ST_RUN);
    assign md_stall = busy | (start & long_op);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (long_op) begin
                        pending_next = core_result;
                        cnt_next     = latency;
                        state_next   = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_next = rs_val;
                    end else if (op == OP_MTLO) begin
                        lo_next = rs_val;
                    end
                end
            end
            ST_RUN: begin
                // Any start seen here is dropped; the hazard unit should never issue one.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    hi_next    = pending_reg[63:32];
                    lo_next    = pending_reg[31:0];
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            pending_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO/latency, a monitor checks on busy falling.
// Covers the MDU_ACC_EN build when the macro is defined for the bench too.
module tb_mdu;
    import mdu_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [OP_W-1:0] op = '0;
    logic [31:0]     rs_val = '0;
    logic [31:0]     rt_val = '0;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic            busy;
    logic            md_stall;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic abort_flag = 1'b0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input int cyc);
        exp_t e;
        e.hi = e_hi; e.lo = e_lo; e.cyc = cyc; e.name = name;
        exp_q.push_back(e);
    endtask

    // Presents one op for a single cycle; checks md_stall while it is presented.
    task automatic issue(input logic [OP_W-1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        @(posedge clk);
        #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        check($sformatf("md_stall_present_op%0d", o), {63'b0, md_stall}, {63'b0, exp_stall});
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("issue op=%0d rs=0x%08h rt=0x%08h busy=%0b hi=0x%08h lo=0x%08h",
                 o, a, b, busy, hi, lo);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, {63'b0, done}, 64'd1);
    endtask

    // Monitor: counts busy cycles and md_stall while busy, compares on completion.
    initial begin : monitor
        int   bcnt = 0;
        logic stall_bad = 1'b0;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (!md_stall) stall_bad = 1'b1;
            end else if (prev_busy) begin
                if (abort_flag) begin
                    abort_flag = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("done %s: hi=0x%08h lo=0x%08h busy_cycles=%0d", e.name, hi, lo, bcnt);
                    check({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
                    check({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
                    check({e.name, "_cycles"}, 64'(bcnt), 64'(e.cyc));
                    check({e.name, "_stall_while_busy"}, {63'b0, stall_bad}, 64'd0);
                end
                bcnt = 0;
                stall_bad = 1'b0;
            end
            prev_busy = busy;
        end
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_md_stall", {63'b0, md_stall}, 64'd0);
        #2 reset = 1'b1;

        push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_idle("mult");

        push("multu", 32'h00000002, 32'hFFFFFFFA, 5);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_idle("multu");

        push("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle("div_neg");

        push("divu", 32'd1, 32'd3, 10);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b1);
        wait_idle("divu");

        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'b0, lo}, 64'd3);
        check("mthi_no_busy", {63'b0, busy}, 64'd0);

        push("div_by_zero", 32'h1234, 32'd3, 10);
        issue(OP_DIV, 32'd5, 32'd0, 1'b1);
        wait_idle("div_by_zero");

        push("div_overflow", 32'd0, 32'h80000000, 10);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_idle("div_overflow");

        push("div_neg_divisor", 32'd1, 32'hFFFFFFFD, 10);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1);
        wait_idle("div_neg_divisor");

        // DIV with an MTLO pulsed at busy cycle 3; the MTLO must be dropped.
        push("div_ignore_mtlo", 32'd2, 32'd14, 10);
        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1; op = OP_MTLO; rs_val = 32'hAA;
        #1;
        check("md_stall_mtlo_while_busy", {63'b0, md_stall}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo_ignored_lo", {32'b0, lo}, 64'hFFFFFFFD);
        wait_idle("div_ignore_mtlo");

`ifdef MDU_ACC_EN
        issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MTLO, 32'd5, 32'd0, 1'b0);
        check("acc_init_lo", {32'b0, lo}, 64'd5);
        push("madd", 32'd0, 32'd11, 5);
        issue(OP_MADD, 32'd2, 32'd3, 1'b1);
        wait_idle("madd");
        push("msub", 32'hFFFFFFFF, 32'hFFFFFFFB, 5);
        issue(OP_MSUB, 32'd4, 32'd4, 1'b1);
        wait_idle("msub");
`else
        issue(OP_MADD, 32'd2, 32'd3, 1'b0);
        check("op6_no_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        check("op6_no_busy_later", {63'b0, busy}, 64'd0);
        check("op6_hi_kept", {32'b0, hi}, 64'd2);
        check("op6_lo_kept", {32'b0, lo}, 64'd14);
`endif

        // Reset between edges at busy cycle 2 aborts the MULT immediately.
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {63'b0, busy}, 64'd1);
        #1;
        abort_flag = 1'b1;
        reset = 1'b0;
        #1;
        $display("reset mid-run: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_idle", {63'b0, busy}, 64'd0);

        push("mult_after_reset", 32'd0, 32'd12, 5);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        wait_idle("mult_after_reset");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
